// File: rtl/fetch_pkg.sv
// Shared fetch/controller definitions: phase numbering, opcodes, run/halt state.
package fetch_pkg;

    localparam int PHW = 3;

    localparam logic [PHW-1:0] PH_INST_ADDR  = 3'd0;
    localparam logic [PHW-1:0] PH_INST_FETCH = 3'd1;
    localparam logic [PHW-1:0] PH_INST_LOAD  = 3'd2;
    localparam logic [PHW-1:0] PH_IDLE       = 3'd3;
    localparam logic [PHW-1:0] PH_OP_ADDR    = 3'd4;
    localparam logic [PHW-1:0] PH_OP_FETCH   = 3'd5;
    localparam logic [PHW-1:0] PH_ALU_OP     = 3'd6;
    localparam logic [PHW-1:0] PH_STORE      = 3'd7;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } run_state_t;

endpackage

// File: rtl/phase_counter.sv
// Free-running 3-bit instruction phase with run/halt control; owns the halted flag.
module phase_counter
    import fetch_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           halt,
    input  logic           resume,
    input  logic           brk,
    output logic [PHW-1:0] phase,
    output logic           halted
);

    run_state_t     state, state_next;
    logic [PHW-1:0] phase_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            phase <= PH_INST_ADDR;
        end else begin
            state <= state_next;
            phase <= phase_next;
        end
    end

    // halt freezes the phase; a breakpoint lets the 7->0 wrap complete first
    always_comb begin
        state_next = state;
        phase_next = phase;
        case (state)
            ST_RUN: begin
                if (halt) begin
                    state_next = ST_HALT;
                end else begin
                    phase_next = phase + 3'd1;
                    if (brk) state_next = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_next = ST_RUN;
                    phase_next = phase + 3'd1;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    assign halted = (state == ST_HALT);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: phase generation, PC, IR and memory address mux.
// Optional breakpoint support with FETCH_SEQUENCER_BREAKPOINT_EN.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int AWIDTH  = 5,
    parameter int DWIDTH  = 8,
    parameter int OPWIDTH = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [DWIDTH-1:0]  mem_data,
    input  logic               sel,
    input  logic               halt,
    input  logic               ld_ir,
    input  logic               inc_pc,
    input  logic               ld_pc,
    input  logic               resume,
`ifdef FETCH_SEQUENCER_BREAKPOINT_EN
    input  logic               brk_en,
    input  logic [AWIDTH-1:0]  brk_addr,
`endif
    output logic [2:0]         phase,
    output logic [OPWIDTH-1:0] opcode,
    output logic [AWIDTH-1:0]  ir_addr,
    output logic [AWIDTH-1:0]  pc,
    output logic [AWIDTH-1:0]  mem_addr,
    output logic               halted
);

    logic [DWIDTH-1:0] ir;
    logic [AWIDTH-1:0] pc_next;
    logic              brk;

    phase_counter u_phase (
        .clk    (clk),
        .rst    (rst),
        .halt   (halt),
        .resume (resume),
        .brk    (brk),
        .phase  (phase),
        .halted (halted)
    );

    // PC strobes are dropped on the halting edge as well as while halted
    always_comb begin
        pc_next = pc;
        if (!halted && !halt) begin
            if (ld_pc)       pc_next = ir_addr;
            else if (inc_pc) pc_next = pc + AWIDTH'(1);
        end
    end

`ifdef FETCH_SEQUENCER_BREAKPOINT_EN
    assign brk = brk_en && !halted && (phase == PH_STORE) && (pc_next == brk_addr);
`else
    assign brk = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            ir <= '0;
        end else begin
            pc <= pc_next;
            if (ld_ir && !halted) ir <= mem_data;
        end
    end

    assign opcode   = ir[DWIDTH-1 -: OPWIDTH];
    assign ir_addr  = ir[AWIDTH-1:0];
    assign mem_addr = sel ? pc : ir_addr;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Upstream stage of the CPU controller. Generates the 3-bit instruction phase and holds the program counter and instruction register.
- Supplies the controller with phase, opcode and the halted status. Consumes the controller's sel, halt, ld_ir, inc_pc and ld_pc strobes.
- Drives the memory address: PC during fetch, IR operand address during execute.

Parameters:
- AWIDTH, 5, address width of PC, IR operand field and mem_addr.
- DWIDTH, 8, instruction/memory data width; must equal OPWIDTH + AWIDTH.
- OPWIDTH, 3, opcode field width (IR upper bits).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mem_data  input  DWIDTH  instruction word read from memory.
- sel  input  1  from controller: 1 = address from PC, 0 = address from IR operand.
- halt  input  1  from controller: stop sequencing.
- ld_ir  input  1  from controller: capture mem_data into IR.
- inc_pc  input  1  from controller: PC + 1.
- ld_pc  input  1  from controller: PC <= IR operand.
- resume  input  1  restart after halt, single-cycle pulse.
- phase  output  3  current phase, 0..7.
- opcode  output  OPWIDTH  IR[DWIDTH-1 -: OPWIDTH].
- ir_addr  output  AWIDTH  IR[AWIDTH-1:0].
- pc  output  AWIDTH  program counter.
- mem_addr  output  AWIDTH  combinational: sel ? pc : ir_addr.
- halted  output  1  sequencer stopped.

Behaviour:
- Reset (async, rst=1): phase=0, pc=0, IR=0 (so opcode=0, ir_addr=0), halted=0. mem_addr follows sel combinationally.
- Running (halted=0): phase increments by 1 on every clk and wraps 7 -> 0. No idle states.
- Phase encoding:
  - 0 INST_ADDR
  - 1 INST_FETCH
  - 2 INST_LOAD
  - 3 IDLE
  - 4 OP_ADDR
  - 5 OP_FETCH
  - 6 ALU_OP
  - 7 STORE
- State machine, two states:
  - RUN -> HALT when halt=1 at a clk edge. halted<=1 on that edge; phase holds its current value (does not advance).
  - HALT -> RUN when resume=1. halted<=0; phase advances by 1 on the same edge.
  - resume in RUN is ignored.
  - halt and resume both high in HALT: resume wins, but the sequencer re-halts on the next edge if halt is still high.
- PC (only when halted=0 and halt=0):
  - ld_pc=1: pc<=ir_addr.
  - else inc_pc=1: pc<=pc+1, modulo 2^AWIDTH (31 -> 0 for default).
  - ld_pc has priority over inc_pc.
- IR: ld_ir=1 and halted=0: IR<=mem_data. ld_ir is honoured on the halting edge itself.
- All of ld_ir, inc_pc and ld_pc are ignored while halted=1.
- Latency: opcode and ir_addr are valid the cycle after the capturing edge. pc update is visible one cycle after the strobe.
- Reset mid-instruction: everything returns to reset values immediately. The first clk after rst deasserts moves phase 0 -> 1.
- Outputs phase, pc, opcode, ir_addr and halted are registered; mem_addr is the only combinational output.

Optional Feature:
- Macro: FETCH_SEQUENCER_BREAKPOINT_EN.
- Defined:
  - Adds ports brk_en (input, 1) and brk_addr (input, AWIDTH).
  - On the edge where phase wraps 7 -> 0, if brk_en=1 and the next pc equals brk_addr, then halted<=1 and phase holds at 0.
  - resume restarts as normal.
  - A breakpoint and halt on the same edge produce a single halt.
- Undefined: the ports are absent and there is no breakpoint logic.

Decomposition:
- Package fetch_pkg:
  - phase localparams: PH_INST_ADDR..PH_STORE.
  - opcode localparams: OP_HLT=0, OP_SKZ=1, OP_ADD=2, OP_AND=3, OP_XOR=4, OP_LDA=5, OP_STO=6, OP_JMP=7.
  - Run/halt state enum.
  - Shared by the controller.
- Sub-module phase_counter: 3-bit wrap counter with hold and resume inputs, owns the halted flag. PC, IR and the address mux stay in fetch_sequencer.

Test Plan:
- Reset release, no strobes -> phase steps 0,1,...,7,0 on successive clocks; pc=0; halted=0.
- mem_data=8'hA5 with ld_ir=1 in phase 2 -> next cycle opcode=3'b101, ir_addr=5'h05. With sel=0, mem_addr=5'h05.
- pc=31 and inc_pc=1 -> pc=0. With ir_addr=5'h0C, ld_pc=1 and inc_pc=1 together -> pc=5'h0C.
- halt=1 in phase 4 -> halted=1; phase stays 4 for 10 clocks; inc_pc pulses ignored (pc unchanged). resume pulse -> halted=0, phase=5 next cycle.
- rst asserted asynchronously mid phase 6 with pc=9 -> phase=0, pc=0, IR=0 before the next clk edge.
- With FETCH_SEQUENCER_BREAKPOINT_EN defined: brk_en=1, brk_addr=3, program incrementing pc once per instruction -> halted=1 at phase 0 with pc=3. resume -> phase=1.
